// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: receive-only PS/2 keyboard interface.
// Conditions the keyboard clock/data lines, assembles 11-bit device-to-host
// frames, validates start/parity/stop and presents each good byte with a
// one-cycle strobe plus a held copy for display logic.
//
// Handshake: ps2_key_pressed is a one-cycle valid pulse with no ready;
// ps2_key_data is meaningful in that cycle, and the consumer must take
// it then. ps2_out keeps the last good byte until the next good frame.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  // Open-collector lines. Nothing here drives them, so they stay high-Z
  // from this block and are only read.
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd10;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;

  logic [FW-1:0] filt_cnt;
  logic          filt_clk;
  logic          filt_prev;
  logic          fall_edge;

  logic [3:0]    bit_cnt;
  logic [10:0]   shift_reg;
  logic [TW-1:0] to_cnt;

  logic [10:0]   shift_next;
  logic          frame_ok;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Two-flop synchronizers, preset high to match the idle line level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clock};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock follows the synchronized clock only
  // after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_cnt <= '0;
      filt_clk <= 1'b1;
    end else if (clk_s != filt_clk) begin
      if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Delayed copy of the filtered clock for single-cycle edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
    end
  end

  assign fall_edge = filt_prev & ~filt_clk;

  // Frame as it will look once the current data bit is shifted in (LSB
  // first, so the newest bit enters at the top). On the 11th edge this is
  // the complete frame: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign shift_next = {dat_s, shift_reg[10:1]};
  assign frame_ok   = ~shift_next[0] & shift_next[10] & (^shift_next[9:1]);

  // Bit capture, start-bit resync and mid-frame timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      to_cnt    <= '0;
    end else if (fall_edge) begin
      to_cnt <= '0;
      if ((bit_cnt == 4'd0) && dat_s) begin
        // A start bit of 1 is line noise; drop it and keep waiting.
        bit_cnt <= '0;
      end else begin
        shift_reg <= shift_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end else if (bit_cnt != 4'd0) begin
      if (to_cnt == TO_LAST) begin
        // Keyboard went quiet mid-frame: abandon the partial frame.
        bit_cnt   <= '0;
        shift_reg <= '0;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end

  // Output registers: a good frame loads both byte outputs and pulses the
  // strobe for the single cycle after the final edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2_key_data    <= '0;
      ps2_key_pressed <= 1'b0;
      ps2_out         <= '0;
    end else begin
      ps2_key_pressed <= 1'b0;
      if (fall_edge && (bit_cnt == LAST_BIT) && frame_ok) begin
        ps2_key_data    <= shift_next[8:1];
        ps2_out         <= shift_next[8:1];
        ps2_key_pressed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: bench for ps2_keyboard_rx with a scoreboard of
// expected bytes and a reference model built from the frame rules.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF_BIT       = 40;   // PS/2 clock half period, sys clocks

  logic       clk;
  logic       rst;
  logic       clk_drv;
  logic       dat_drv;
  wire        ps2_clock;
  wire        ps2_data;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;

  assign ps2_clock = clk_drv;
  assign ps2_data  = dat_drv;

  ps2_keyboard_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock           (clk),
    .reset           (rst),
    .ps2_clock       (ps2_clock),
    .ps2_data        (ps2_data),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_out         (ps2_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] model_out;
  int         total;
  int         bad;

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One bit: data set while clock is high, then a full low/high clock pulse.
  task automatic send_bit(input logic b);
    dat_drv = b;
    wait_cycles(HALF_BIT / 2);
    clk_drv = 1'b0;
    wait_cycles(HALF_BIT);
    clk_drv = 1'b1;
    wait_cycles(HALF_BIT / 2);
  endtask

  // kind: 0 = good frame, 1 = wrong parity, 2 = stop bit 0.
  // The model expects a byte only when the frame obeys all framing rules.
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    logic        par;
    logic        stp;
    par = ~(^b);
    stp = 1'b1;
    if (kind == 1) par = ~par;
    if (kind == 2) stp = 1'b0;
    f = {stp, par, b, 1'b0};
    if (kind == 0) begin
      exp_q.push_back(b);
      model_out = b;
    end
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    dat_drv = 1'b1;
    wait_cycles(60);
  endtask

  // Only the first n bits of a good frame.
  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = {1'b1, ~(^b), b, 1'b0};
    for (int i = 0; i < n; i++) send_bit(f[i]);
    dat_drv = 1'b1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check8({name, "_key_data"}, ps2_key_data, 8'h00);
    check8({name, "_pressed"}, {7'd0, ps2_key_pressed}, 8'h00);
    check8({name, "_out"}, ps2_out, 8'h00);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic       prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ps2_key_pressed === 1'b1) begin
        total++;
        if (prev) begin
          bad++;
          $display("FAIL strobe_spacing: strobe high two cycles in a row");
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: got byte %02h want no strobe", ps2_key_data);
        end else begin
          e = exp_q.pop_front();
          if (ps2_key_data !== e || ps2_out !== e) begin
            bad++;
            $display("FAIL strobe_byte: got key_data %02h out %02h want %02h",
                     ps2_key_data, ps2_out, e);
          end
        end
      end
      prev = (ps2_key_pressed === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    total     = 0;
    bad       = 0;
    model_out = 8'h00;
    clk_drv   = 1'b1;
    dat_drv   = 1'b1;
    rst       = 1'b1;

    // Reset with idle lines, then a long quiet period.
    wait_cycles(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cycles(1000);
    check8("idle_out", ps2_out, 8'h00);
    check8("idle_key_data", ps2_key_data, 8'h00);

    // Single good frame; value must hold afterwards.
    send_frame(8'h1C, 0);
    wait_cycles(200);
    check8("hold_out_1c", ps2_out, 8'h1C);

    // Back-to-back frames.
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);

    // Framing errors leave ps2_out alone.
    send_frame(8'h1C, 1);
    send_frame(8'h1C, 2);
    check8("after_errors_out", ps2_out, model_out);

    // Abandoned partial frame followed by a good one.
    send_partial(8'h55, 5);
    wait_cycles(TIMEOUT_CYCLES + 500);
    send_frame(8'h3A, 0);

    // Short clock glitches while idle must not be taken as bits.
    for (int g = 0; g < 4; g++) begin
      clk_drv = 1'b0;
      wait_cycles(3);
      clk_drv = 1'b1;
      wait_cycles(20);
    end
    send_frame(8'h66, 0);

    // A stray falling edge with data high is not a start bit.
    send_bit(1'b1);
    send_frame(8'hE0, 0);

    // Randomized mix of good and damaged frames.
    for (int k = 0; k < 14; k++) begin
      logic [7:0] b;
      int         r;
      int         kind;
      b    = 8'($urandom_range(0, 255));
      r    = $urandom_range(0, 9);
      kind = (r < 7) ? 0 : ((r == 7) ? 1 : 2);
      send_frame(b, kind);
      wait_cycles($urandom_range(10, 200));
    end
    wait_cycles(100);
    check8("random_out", ps2_out, model_out);

    // Reset in the middle of a frame abandons it.
    send_partial(8'h77, 6);
    rst = 1'b1;
    wait_cycles(3);
    check_reset_outputs("midreset");
    model_out = 8'h00;
    clk_drv   = 1'b1;
    dat_drv   = 1'b1;
    rst       = 1'b0;
    wait_cycles(100);
    send_frame(8'h29, 0);
    wait_cycles(200);
    check8("final_out", ps2_out, 8'h29);

    // Every expected byte must have been delivered.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_strobes: got %0d undelivered want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receive-only PS/2 keyboard interface.
- Samples the keyboard clock/data lines, assembles 11-bit device-to-host frames and validates start, parity and stop bits.
- Presents each valid scan-code byte with a one-cycle strobe, and holds the last valid byte for seven-segment/LCD display.
- Sits between the board PS/2 pins and the processor/display logic in the top level.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level (glitch filter).
- TIMEOUT_CYCLES, 50000: system clocks with no filtered PS/2 clock falling edge mid-frame before the partial frame is aborted (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock, 50 MHz; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps2_clock  inout  1  PS/2 clock line; never driven (held high-Z), read only.
- ps2_data  inout  1  PS/2 data line; never driven (held high-Z), read only.
- ps2_key_data  output  8  byte from the most recent valid frame.
- ps2_key_pressed  output  1  one-cycle strobe, a valid frame was received.
- ps2_out  output  8  last valid byte received, held until the next valid frame.

Behaviour:
- Reset (async, active-high):
  - ps2_key_data=0, ps2_key_pressed=0, ps2_out=0.
  - Bit counter=0, shift register=0, timeout counter=0.
  - Synchronizers and filtered clock preset to 1 (idle-high lines).
- Input conditioning:
  - ps2_clock and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock changes only after FILTER_LEN consecutive equal synchronized clock samples; shorter glitches are ignored.
  - A falling edge is a filtered-clock 1->0 transition, detected as a single-cycle event.
- Bit capture: on each falling edge, the synchronized ps2_data is shifted in (bits arrive LSB first) and the bit counter increments.
- Frame, in order:
  - bit0 = start (must be 0);
  - bits1-8 = data D0..D7;
  - bit9 = odd parity (D0..D7 plus parity has an odd count of ones);
  - bit10 = stop (must be 1).
- Start-bit check: if bit0 is sampled as 1, it is discarded immediately and the counter stays 0 (resync on line noise).
- Completion: on the 11th falling edge, in the cycle following that edge event:
  - if start=0, parity correct and stop=1: ps2_key_data and ps2_out load D7..D0, and ps2_key_pressed=1 for exactly one cycle;
  - otherwise no outputs change and no strobe.
  - Either way the counter returns to 0.
- Timeout: while the counter is nonzero, the timeout counter increments each cycle and clears on every falling edge. Reaching TIMEOUT_CYCLES clears the bit counter and shift register, with no output change.
- No decoding: make/break codes are not interpreted. 0xF0, 0xE0 etc. are delivered like any other byte.
- ps2_key_pressed is never high on two consecutive cycles; minimum spacing equals one full frame.
- Reset mid-frame abandons the partial frame. The next frame after reset release is received normally.
- Lines are treated as open-collector inputs; outputs are never enabled.

Test Plan:
- Reset behaviour: assert reset with lines idle high -> all outputs 0. Release, hold idle 10k cycles -> no strobe, outputs stay 0.
- Single valid frame: send byte 0x1C (start 0, data LSB-first, parity 0, stop 1) at 12.5 kHz PS/2 clock -> exactly one ps2_key_pressed pulse; ps2_key_data=0x1C, ps2_out=0x1C, holding afterward.
- Back-to-back frames: send 0xF0 (parity 1) then 0x1C -> two pulses; first with data 0xF0, final ps2_out=0x1C.
- Errors: send 0x1C with parity 1 -> no pulse, ps2_out keeps prior value. Send 0x1C with stop bit 0 -> no pulse.
- Timeout and glitch:
  - send 5 bits, idle 60000 cycles, then full valid 0x3A frame -> single pulse with 0x3A (partial discarded).
  - inject 3-cycle low glitches on ps2_clock during idle -> no bit captured, next frame received correctly.
- Reset mid-frame: assert reset after 6 bits of a frame -> outputs 0. Next complete 0x29 frame -> pulse with ps2_out=0x29.
